// File: rtl/output_transfer_scheduler_pkg.sv
// Shared types and sizing helpers for the output transfer scheduler.
package output_transfer_scheduler_pkg;

  // Per-stream lifecycle: issuing, waiting for completions, notifying, finished.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    NOTIFY = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  localparam int DEF_N_STREAMS       = 4;
  localparam int DEF_MAX_OUTSTANDING = 8;
  localparam int DEF_LEN_BITS        = 28;

  // Stream id width; a single stream still gets a 1-bit id.
  function automatic int sw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Outstanding counter width, able to hold 0..max inclusive.
  function automatic int cnt_w_of(input int max_out);
    return (max_out > 0) ? $clog2(max_out + 1) : 1;
  endfunction

  localparam int DEF_SW = sw_of(DEF_N_STREAMS);
  localparam int DEF_CW = cnt_w_of(DEF_MAX_OUTSTANDING);

endpackage

// File: rtl/output_transfer_scheduler_stream_rr_picker.sv
// N-way round-robin picker: first eligible stream at or after ptr_i wins.
module stream_rr_picker
  import output_transfer_scheduler_pkg::*;
#(
  parameter int N  = DEF_N_STREAMS,
  parameter int PW = sw_of(N)
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  winner_o,
  output logic          valid_o
);

  // Scan from the pointer, wrapping once; the first hit is the winner.
  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!valid_o && eligible_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_transfer_scheduler.sv
// Output-path transfer scheduler: arbitrates stream requests onto the send
// queue, limits outstanding transfers per stream with completion credits and
// raises one notify per stream after its final transfer has completed.
module output_transfer_scheduler
  import output_transfer_scheduler_pkg::*;
#(
  parameter int  N_STREAMS       = DEF_N_STREAMS,
  parameter int  MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int  LEN_BITS        = DEF_LEN_BITS,
  localparam int SW              = sw_of(N_STREAMS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_STREAMS-1:0]          req_valid,
  output logic [N_STREAMS-1:0]          req_ready,
  input  logic [N_STREAMS*LEN_BITS-1:0] req_len,
  input  logic [N_STREAMS-1:0]          req_last,
  output logic                          sq_valid,
  input  logic                          sq_ready,
  output logic [SW-1:0]                 sq_strm,
  output logic [LEN_BITS-1:0]           sq_len,
  output logic                          sq_last,
  input  logic                          cq_valid,
  input  logic [SW-1:0]                 cq_strm,
  output logic                          irq_valid,
  input  logic                          irq_ready,
  output logic [SW-1:0]                 irq_strm,
  output logic [N_STREAMS-1:0]          done,
  output logic                          err
);

  localparam int            CW      = cnt_w_of(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [SW:0]   N_LIM   = (SW + 1)'(N_STREAMS);

  sched_state_t        state_q [N_STREAMS];
  logic [CW-1:0]       cnt_q   [N_STREAMS];
  logic [SW-1:0]       ptr_q;
  logic                sq_valid_q;
  logic [SW-1:0]       sq_strm_q;
  logic [LEN_BITS-1:0] sq_len_q;
  logic                sq_last_q;
  logic                irq_valid_q;
  logic [SW-1:0]       irq_strm_q;
  logic                err_q;

  logic [N_STREAMS-1:0] eligible;
  logic [N_STREAMS-1:0] win_oh;
  logic                 win_valid;
  logic [SW-1:0]        win_idx;
  logic [LEN_BITS-1:0]  sel_len;
  logic                 sel_last;
  logic                 slot_free;
  logic                 grant_fire;
  logic [SW-1:0]        ptr_d;
  logic                 cq_in_range;
  logic [N_STREAMS-1:0] cq_hit;
  logic [N_STREAMS-1:0] cnt_zero;
  logic [N_STREAMS-1:0] in_notify;
  logic                 notify_any;
  logic [SW-1:0]        notify_idx;
  logic                 irq_fire;

  assign cq_in_range = ({1'b0, cq_strm} < N_LIM);
  assign irq_fire    = irq_valid_q && irq_ready;

  for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_flags
    assign cnt_zero[gi]  = (cnt_q[gi] == '0);
    assign eligible[gi]  = req_valid[gi] && (state_q[gi] == ACTIVE) && (cnt_q[gi] < CNT_MAX);
    assign cq_hit[gi]    = cq_valid && cq_in_range && (cq_strm == SW'(gi));
    assign in_notify[gi] = (state_q[gi] == NOTIFY);
    assign done[gi]      = (state_q[gi] == DONE);
  end

  stream_rr_picker #(
    .N  (N_STREAMS),
    .PW (SW)
  ) u_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .winner_o   (win_oh),
    .valid_o    (win_valid)
  );

  // A grant needs a free output slot; nothing is accepted while in reset.
  assign slot_free  = !sq_valid_q || sq_ready;
  assign grant_fire = slot_free && win_valid && !rst;
  assign req_ready  = grant_fire ? win_oh : '0;

  // Encode the one-hot winner and mux its request fields.
  always_comb begin
    win_idx  = '0;
    sel_len  = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_STREAMS; i++) begin
      if (win_oh[i]) begin
        win_idx  = SW'(i);
        sel_len  = req_len[i*LEN_BITS +: LEN_BITS];
        sel_last = req_last[i];
      end
    end
  end

  assign ptr_d = (win_idx == SW'(N_STREAMS - 1)) ? '0 : win_idx + SW'(1);

  // Lowest-indexed stream waiting to notify; scanned downward so index 0 wins.
  always_comb begin
    notify_any = 1'b0;
    notify_idx = '0;
    for (int i = N_STREAMS - 1; i >= 0; i--) begin
      if (in_notify[i]) begin
        notify_any = 1'b1;
        notify_idx = SW'(i);
      end
    end
  end

  // Send-queue output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_valid_q <= 1'b0;
      sq_strm_q  <= '0;
      sq_len_q   <= '0;
      sq_last_q  <= 1'b0;
      ptr_q      <= '0;
    end else if (grant_fire) begin
      sq_valid_q <= 1'b1;
      sq_strm_q  <= win_idx;
      sq_len_q   <= sel_len;
      sq_last_q  <= sel_last;
      ptr_q      <= ptr_d;
    end else if (sq_ready) begin
      sq_valid_q <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_stream
    logic inc_s;
    logic dec_s;
    assign inc_s = req_ready[gi];
    assign dec_s = cq_hit[gi] && !cnt_zero[gi];

    // Outstanding credits: grant takes one, completion returns one.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[gi] <= '0;
      end else if (inc_s && !dec_s) begin
        cnt_q[gi] <= cnt_q[gi] + CW'(1);
      end else if (dec_s && !inc_s) begin
        cnt_q[gi] <= cnt_q[gi] - CW'(1);
      end
    end

    // Stream lifecycle; DONE is only left through reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q[gi] <= ACTIVE;
      end else begin
        case (state_q[gi])
          ACTIVE:  if (req_ready[gi] && req_last[gi]) state_q[gi] <= DRAIN;
          DRAIN:   if (cnt_zero[gi]) state_q[gi] <= NOTIFY;
          NOTIFY:  if (irq_fire && (irq_strm_q == SW'(gi))) state_q[gi] <= DONE;
          DONE:    state_q[gi] <= DONE;
          default: state_q[gi] <= ACTIVE;
        endcase
      end
    end
  end

  // Notify register: load a waiting stream only when idle, hold until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_valid_q <= 1'b0;
      irq_strm_q  <= '0;
    end else if (irq_valid_q) begin
      if (irq_ready) irq_valid_q <= 1'b0;
    end else if (notify_any) begin
      irq_valid_q <= 1'b1;
      irq_strm_q  <= notify_idx;
    end
  end

  // Sticky error on a completion with no matching outstanding transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (cq_valid && (!cq_in_range || |(cq_hit & cnt_zero))) begin
      err_q <= 1'b1;
    end
  end

  assign sq_valid  = sq_valid_q;
  assign sq_strm   = sq_strm_q;
  assign sq_len    = sq_len_q;
  assign sq_last   = sq_last_q;
  assign irq_valid = irq_valid_q;
  assign irq_strm  = irq_strm_q;
  assign err       = err_q;

endmodule

// File: tb/tb_output_transfer_scheduler.sv
// Directed bench for the output transfer scheduler (4 streams, 2 credits each).
module tb_output_transfer_scheduler;

  localparam int N  = 4;
  localparam int MX = 2;
  localparam int LB = 28;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*LB-1:0] req_len;
  logic [N-1:0]    req_last;
  logic            sq_valid;
  logic            sq_ready;
  logic [SW-1:0]   sq_strm;
  logic [LB-1:0]   sq_len;
  logic            sq_last;
  logic            cq_valid;
  logic [SW-1:0]   cq_strm;
  logic            irq_valid;
  logic            irq_ready;
  logic [SW-1:0]   irq_strm;
  logic [N-1:0]    done;
  logic            err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  output_transfer_scheduler #(
    .N_STREAMS       (N),
    .MAX_OUTSTANDING (MX),
    .LEN_BITS        (LB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_len   (req_len),
    .req_last  (req_last),
    .sq_valid  (sq_valid),
    .sq_ready  (sq_ready),
    .sq_strm   (sq_strm),
    .sq_len    (sq_len),
    .sq_last   (sq_last),
    .cq_valid  (cq_valid),
    .cq_strm   (cq_strm),
    .irq_valid (irq_valid),
    .irq_ready (irq_ready),
    .irq_strm  (irq_strm),
    .done      (done),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle after an input change, then check req_ready.
  task automatic chk_rr(input string tag, input logic [N-1:0] exp);
    #1;
    chk(tag, 64'(req_ready), 64'(exp));
  endtask

  task automatic chk_sq(input string tag, input logic [SW-1:0] strm, input logic [LB-1:0] len);
    chk({tag, "_valid"}, 64'(sq_valid), 64'd1);
    chk({tag, "_strm"}, 64'(sq_strm), 64'(strm));
    chk({tag, "_len"}, 64'(sq_len), 64'(len));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_len = '0; req_last = '0;
    sq_ready = 1'b1; cq_valid = 1'b0; cq_strm = '0; irq_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_sq_valid", 64'(sq_valid), 64'd0);
    chk("rst_irq_valid", 64'(irq_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_sq_strm", 64'(sq_strm), 64'd0);
    chk("rst_sq_len", 64'(sq_len), 64'd0);
    chk("rst_sq_last", 64'(sq_last), 64'd0);
    chk("rst_irq_strm", 64'(irq_strm), 64'd0);
    rst = 1'b0;

    // Round robin with every stream requesting: 0,1,2,3,0,1,2,3 then credit stall
    for (int s = 0; s < N; s++) req_len[s*LB +: LB] = LB'(32'h10 + s);
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      chk_rr($sformatf("rr_grant%0d", i), 4'(1 << (i % 4)));
      tick();
      chk_sq($sformatf("rr_sq%0d", i), SW'(i % 4), LB'(32'h10 + (i % 4)));
      $display("rr step %0d: sq_strm=%0d sq_len=%0h", i, sq_strm, sq_len);
    end
    chk_rr("credit_stall0", 4'b0000);
    tick();
    chk("credit_stall_sq_valid", 64'(sq_valid), 64'd0);
    chk_rr("credit_stall1", 4'b0000);
    tick();

    // Completion for stream 1 frees its credit only from the next cycle
    cq_valid = 1'b1; cq_strm = 2'd1;
    chk_rr("cq_no_comb_path", 4'b0000);
    tick();
    // Grant and completion for stream 1 in the same cycle: count stays at 1
    chk_rr("cq_regrant1", 4'b0010);
    tick();
    chk("cq_regrant1_strm", 64'(sq_strm), 64'd1);
    cq_valid = 1'b0;
    chk_rr("cq_same_cycle_kept", 4'b0010);
    tick();
    chk("cq_regrant2_strm", 64'(sq_strm), 64'd1);
    req_len[2*LB +: LB] = LB'(32'h40);
    cq_valid = 1'b1; cq_strm = 2'd2;
    chk_rr("cq_back_at_max", 4'b0000);
    tick();
    cq_valid = 1'b0;
    chk_rr("grant_s2", 4'b0100);
    tick();
    chk_sq("grant_s2_sq", 2'd2, LB'(32'h40));

    // Send queue stalled for 5 cycles: fields hold, no grants
    sq_ready = 1'b0;
    cq_valid = 1'b1; cq_strm = 2'd0;
    for (int k = 0; k < 5; k++) begin
      chk_rr($sformatf("stall_rr%0d", k), 4'b0000);
      tick();
      cq_valid = 1'b0;
      chk_sq($sformatf("stall_sq%0d", k), 2'd2, LB'(32'h40));
      $display("stall cycle %0d: sq_strm=%0d sq_len=%0h", k, sq_strm, sq_len);
    end
    sq_ready = 1'b1;
    chk_rr("after_stall_rr", 4'b0001);
    tick();
    chk_sq("after_stall_sq", 2'd0, LB'(32'h10));

    // Reset mid-burst drops the pending beat; completions during reset ignored
    sq_ready = 1'b0; rst = 1'b1;
    cq_valid = 1'b1; cq_strm = 2'd0;
    chk_rr("rst_mid_rr", 4'b0000);
    tick();
    chk("rst_mid_sq_valid", 64'(sq_valid), 64'd0);
    chk("rst_mid_sq_strm", 64'(sq_strm), 64'd0);
    chk("rst_mid_sq_len", 64'(sq_len), 64'd0);
    chk("rst_mid_sq_last", 64'(sq_last), 64'd0);
    chk("rst_mid_irq_valid", 64'(irq_valid), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_err", 64'(err), 64'd0);
    cq_strm = 2'd1;
    tick();
    rst = 1'b0; cq_valid = 1'b0;
    chk("rst_cq_ignored_err", 64'(err), 64'd0);
    chk_rr("rst_ptr_zero", 4'b0001);
    req_valid = '0; sq_ready = 1'b1;

    // Completion with nothing outstanding: sticky err, counter untouched
    cq_valid = 1'b1; cq_strm = 2'd1;
    tick();
    cq_valid = 1'b0;
    chk("err_set", 64'(err), 64'd1);
    req_valid = 4'b0010;
    chk_rr("err_cnt_grant1", 4'b0010);
    tick();
    chk_rr("err_cnt_grant2", 4'b0010);
    tick();
    chk_rr("err_cnt_full", 4'b0000);
    chk("err_sticky", 64'(err), 64'd1);
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", 64'(err), 64'd0);

    // Stream 3: three transfers, last one final, then completions and notify
    req_valid = 4'b1000; req_len[3*LB +: LB] = LB'(32'h100);
    chk_rr("s3_t1", 4'b1000);
    tick();
    chk_sq("s3_t1_sq", 2'd3, LB'(32'h100));
    chk("s3_t1_last", 64'(sq_last), 64'd0);
    req_len[3*LB +: LB] = LB'(32'h200);
    chk_rr("s3_t2", 4'b1000);
    tick();
    chk_sq("s3_t2_sq", 2'd3, LB'(32'h200));
    req_len[3*LB +: LB] = LB'(32'h300); req_last = 4'b1000;
    cq_valid = 1'b1; cq_strm = 2'd3;
    chk_rr("s3_t3_blocked", 4'b0000);
    tick();
    cq_valid = 1'b0;
    chk_rr("s3_t3", 4'b1000);
    tick();
    chk_sq("s3_t3_sq", 2'd3, LB'(32'h300));
    chk("s3_t3_last", 64'(sq_last), 64'd1);
    cq_valid = 1'b1; cq_strm = 2'd3;
    chk_rr("s3_drain_rr0", 4'b0000);
    tick();
    chk_rr("s3_drain_rr1", 4'b0000);
    tick();
    cq_valid = 1'b0;
    tick();
    chk("s3_notify_no_irq_yet", 64'(irq_valid), 64'd0);
    tick();
    chk("s3_irq_valid", 64'(irq_valid), 64'd1);
    chk("s3_irq_strm", 64'(irq_strm), 64'd3);
    chk("s3_not_done", 64'(done), 64'd0);

    // While stream 3's notify waits, streams 0 and 2 finish their final transfers
    req_valid = 4'b0101; req_last = 4'b0101;
    req_len[0*LB +: LB] = LB'(32'hA); req_len[2*LB +: LB] = LB'(32'hB);
    chk_rr("s0_final", 4'b0001);
    tick();
    chk_sq("s0_final_sq", 2'd0, LB'(32'hA));
    chk("s0_final_last", 64'(sq_last), 64'd1);
    cq_valid = 1'b1; cq_strm = 2'd0;
    chk_rr("s2_final", 4'b0100);
    tick();
    chk_sq("s2_final_sq", 2'd2, LB'(32'hB));
    req_valid = '0; cq_strm = 2'd2;
    tick();
    cq_valid = 1'b0;
    tick();
    chk("irq_held_valid", 64'(irq_valid), 64'd1);
    chk("irq_held_strm", 64'(irq_strm), 64'd3);
    irq_ready = 1'b1;
    tick();
    $display("irq handshake: strm=3 done=%b", done);
    chk("s3_done", 64'(done), 64'b1000);
    chk("irq_gap0", 64'(irq_valid), 64'd0);
    tick();
    chk("irq_s0_valid", 64'(irq_valid), 64'd1);
    chk("irq_s0_strm", 64'(irq_strm), 64'd0);
    tick();
    $display("irq handshake: strm=0 done=%b", done);
    chk("s0_done", 64'(done), 64'b1001);
    tick();
    chk("irq_s2_valid", 64'(irq_valid), 64'd1);
    chk("irq_s2_strm", 64'(irq_strm), 64'd2);
    tick();
    $display("irq handshake: strm=2 done=%b", done);
    chk("s2_done", 64'(done), 64'b1101);
    req_valid = 4'hF;
    chk_rr("done_streams_blocked", 4'b0010);
    tick();
    chk("irq_only_once", 64'(irq_valid), 64'd0);
    chk("done_held", 64'(done), 64'b1101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
